// File: rtl/v810_pkg.sv
`default_nettype none
// ============================================================================
// Module      : v810_pkg
// Description : Shared types and constants for the V810 instruction prefetch
//               unit: the queue entry layout, the reset fetch address and the
//               fetch state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package v810_pkg;

  // Fetch address taken out of reset
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF0;

  // One queued halfword together with the address it was fetched from
  typedef struct packed {
    logic [15:0] ir;
    logic [31:0] pc;
  } pf_entry_t;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } pf_state_t;

endpackage : v810_pkg
`default_nettype wire

// File: rtl/v810_pf_fifo.sv
`default_nettype none
// ============================================================================
// Module      : v810_pf_fifo
// Description : Prefetch queue storage. Circular buffer of pf_entry_t with
//               push, pop, flush and an occupancy count. Flush wins over
//               push/pop; nothing moves while ce_i is low.
// Revision    : 1.0 - initial release
// ============================================================================
module v810_pf_fifo
  import v810_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     res_i,
  input  logic                     ce_i,
  input  logic                     push_i,
  input  pf_entry_t                data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output pf_entry_t                head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pf_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   rd_q;
  logic [AW-1:0]   wr_q;
  logic [CW-1:0]   count_q;
  logic            w_push;
  logic            w_pop;

  assign w_push  = ce_i & push_i & ~flush_i;
  assign w_pop   = ce_i & pop_i  & ~flush_i;
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (ce_i) begin
      if (flush_i) begin
        rd_q    <= '0;
        wr_q    <= '0;
        count_q <= '0;
      end else begin
        if (w_push) wr_q <= wr_q + 1'b1;
        if (w_pop)  rd_q <= rd_q + 1'b1;
        count_q <= count_q + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Entry storage needs no reset: an entry is only read once count covers it
  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_q] <= data_i;
  end

endmodule : v810_pf_fifo
`default_nettype wire

// File: rtl/v810_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : v810_prefetch
// Description : V810 instruction prefetch unit. Issues one halfword request
//               at a time on the instruction bus, queues returned halfwords
//               with their addresses and presents the head to the IF stage.
//               A redirect flushes the queue; a request already on the bus
//               when the redirect arrives is completed and its data dropped.
//               Optional macro V810_PREFETCH_BYPASS_EN forwards the bus data
//               straight to the PF outputs when the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module v810_prefetch
  import v810_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        res_i,
  input  logic        ce_i,
  input  logic        redir_i,
  input  logic [31:0] redir_pc_i,
  output logic [31:0] ia_o,
  output logic        ireq_o,
  input  logic        iack_i,
  input  logic [15:0] id_i,
  output logic        pf_valid_o,
  input  logic        pf_ready_i,
  output logic [15:0] pf_ir_o,
  output logic [31:0] pf_pc_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_t     state_q, state_d;
  logic [31:0]   fa_q, fa_d;
  logic [31:0]   ia_hold_q, ia_hold_d;

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_cnt_next;
  pf_entry_t     w_head;
  logic          w_byp;
  logic          w_ack;
  logic          w_push;
  logic          w_fire;
  logic          w_fifo_pop;
  logic          w_flush;

`ifdef V810_PREFETCH_BYPASS_EN
  assign w_byp = ce_i & (state_q == ST_REQ) & iack_i & ~redir_i & (w_count == '0);
`else
  assign w_byp = 1'b0;
`endif

  assign pf_valid_o = (w_count != '0) | w_byp;
  assign pf_ir_o    = w_byp ? id_i : w_head.ir;
  assign pf_pc_o    = w_byp ? fa_q : w_head.pc;

  // A bypassed halfword taken by IF in the same cycle never enters the queue
  assign w_fire     = ce_i & pf_valid_o & pf_ready_i & ~redir_i;
  assign w_fifo_pop = w_fire & (w_count != '0);
  assign w_ack      = ce_i & iack_i & (state_q == ST_REQ);
  assign w_push     = w_ack & ~redir_i & ~(w_byp & pf_ready_i);
  assign w_flush    = ce_i & redir_i;
  assign w_cnt_next = w_count + CW'(w_push) - CW'(w_fifo_pop);

  // During DISCARD the bus must keep seeing the abandoned address
  assign ireq_o = (state_q != ST_IDLE);
  assign ia_o   = (state_q == ST_DISCARD) ? ia_hold_q : fa_q;

  v810_pf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .res_i   (res_i),
    .ce_i    (ce_i),
    .push_i  (w_push),
    .data_i  ({id_i, fa_q}),
    .pop_i   (w_fifo_pop),
    .flush_i (w_flush),
    .head_o  (w_head),
    .count_o (w_count)
  );

  // Next-state, fetch-pointer and held-address selection
  always_comb begin
    state_d   = state_q;
    fa_d      = fa_q;
    ia_hold_d = ia_hold_q;
    case (state_q)
      ST_IDLE: begin
        if (w_count < CW'(DEPTH)) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redir_i) begin
          if (!iack_i) begin
            state_d   = ST_DISCARD;
            ia_hold_d = fa_q;
          end
        end else if (iack_i) begin
          fa_d = fa_q + 32'd2;
          if (w_cnt_next >= CW'(DEPTH)) state_d = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (iack_i) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
    if (redir_i) fa_d = {redir_pc_i[31:1], 1'b0};
  end

  // Sequencer registers, frozen while the clock enable is low
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state_q   <= ST_IDLE;
      fa_q      <= RESET_PC;
      ia_hold_q <= RESET_PC;
    end else if (ce_i) begin
      state_q   <= state_d;
      fa_q      <= fa_d;
      ia_hold_q <= ia_hold_d;
    end
  end

endmodule : v810_prefetch
`default_nettype wire

// File: doc/v810_prefetch.md
V810_PREFETCH -- requirements
Module: v810_prefetch

Interface
REQ-001 DEPTH, 4, queue depth in halfwords; power of two, 2..16.
REQ-002 Reset: one clock; reset is asynchronous and active-high.
REQ-003 CLK  in  1  system clock; all state on rising edge.
REQ-004 RES  in  1  asynchronous active-high reset.
REQ-005 CE  in  1  global clock enable; state and handshakes advance only when high.
REQ-006 REDIR  in  1  branch/redirect strobe from execute.
REQ-007 REDIR_PC  in  32  redirect target; bit 0 ignored.
REQ-008 IA  out  32  instruction bus address; bit 0 always 0.
REQ-009 IREQ  out  1  instruction bus request.
REQ-010 IACK  in  1  bus acknowledge; ID is valid in the same cycle.
REQ-011 ID  in  16  instruction halfword.
REQ-012 PF_VALID  out  1  queue head valid.
REQ-013 PF_READY  in  1  IF stage accepts the head.
REQ-014 PF_IR  out  16  head halfword.
REQ-015 PF_PC  out  32  address of the head halfword.

Function
REQ-016 States SHALL be IDLE, REQ and DISCARD; the fetch pointer FA SHALL be 32 bits with bit 0 held at 0.
REQ-017 IDLE->REQ SHALL occur when the queue count is below DEPTH; IREQ=1 and IA=FA in REQ, and at most one request SHALL be outstanding.
REQ-018 IA SHALL stay stable while IREQ=1 and IACK=0.
REQ-019 On IACK in REQ: push {ID, FA}; FA<=FA+2 with modulo-2^32 wrap (0xFFFFFFFE->0x00000000); stay in REQ if count after push and pop is below DEPTH, else go to IDLE.
REQ-020 Pop SHALL occur on PF_VALID & PF_READY; push and pop in the same cycle SHALL leave count unchanged.
REQ-021 PF_VALID = count>0; PF_IR/PF_PC SHALL be the head entry; PF_VALID=0 when empty, with PF_IR and PF_PC don't-care.
REQ-022 REDIR SHALL flush the queue (count<=0, pop ignored) and set FA<=REDIR_PC&~1 in the same cycle.
REQ-023 REDIR in REQ with IACK=0 SHALL go to DISCARD; DISCARD holds IREQ and the old IA until IACK, drops the data, then goes to REQ at the new FA.
REQ-024 REDIR together with IACK SHALL drop the returned data and go to REQ at the new FA next cycle.
REQ-025 REDIR in DISCARD SHALL update FA only and stay in DISCARD.
REQ-026 Without bypass, latency SHALL be IACK cycle +1 to PF_VALID.
REQ-027 CE=0 SHALL freeze all state; IACK, REDIR and PF_READY are ignored that cycle.

Reset
REQ-028 RES SHALL force FA=0xFFFFFFF0, state IDLE, count 0, IREQ=0, PF_VALID=0, IA=0xFFFFFFF0; the first request SHALL follow in the first CE cycle after release.
REQ-029 RES mid-fetch SHALL abandon the outstanding request without DISCARD.

Configuration
REQ-030 Macro V810_PREFETCH_BYPASS_EN defined: with the queue empty, REQ state, IACK=1 and REDIR=0, ID and FA SHALL drive PF_IR and PF_PC with PF_VALID=1 combinationally; if PF_READY=1 no push occurs.
REQ-031 Macro V810_PREFETCH_BYPASS_EN undefined: PF_* outputs SHALL come from queue state only (REQ-026).

Structure
REQ-032 The package v810_pkg SHALL hold the pf_entry_t typedef {ir[15:0], pc[31:0]}, the RESET_PC constant 0xFFFFFFF0, and the pf_state_t enum.
REQ-033 Queue storage and pointers SHALL form the sub-module v810_pf_fifo (push, pop, flush, count); the FSM, FA and bus logic SHALL live in v810_prefetch.

Verification
REQ-034 Release RES with IACK tied 1 and PF_READY=1 -> IA sequence FFFFFFF0, FFFFFFF2, ...; PF_PC=FFFFFFF0 one cycle after the first IACK.
REQ-035 PF_READY=0, IACK=1, DEPTH=4 -> exactly 4 acks, then IREQ=0 and PF_VALID=1; PF_READY pulsed once -> one new request.
REQ-036 REDIR_PC=0x1235 while IREQ=1 and IACK=0 for 3 cycles -> IA held, returned data dropped, next IA=0x1234, queue empty until the new ack.
REQ-037 FA=0xFFFFFFFE with an ack -> next IA=0x00000000, PF_PC=0xFFFFFFFE.
REQ-038 CE toggled 1/0 during a full run -> identical PF_IR/PF_PC sequence counted in CE cycles.
REQ-039 With V810_PREFETCH_BYPASS_EN, queue empty, IACK with ID=0x9A00 and PF_READY=1 -> PF_VALID=1, PF_IR=0x9A00 that cycle and count stays 0.
